// File: rtl/ex_stage_muldiv_if.sv
// Bundle between ID/EX, the forwarding sources, the EX stage and the EX/MEM register.
// The master side drives ID/EX and forwarding signals; the slave side is the EX stage.
interface ex_stage_muldiv_if #(
  parameter int unsigned DATA_W = 32
);
  logic              pridictor_wrong;
  logic [3:0]        id_ex_alu_op;
  logic              id_ex_reg_dst;
  logic              id_ex_alu_src;
  logic              id_ex_mem_read;
  logic              id_ex_mem_write;
  logic              id_ex_mem_to_reg;
  logic              id_ex_reg_write;
  logic              id_ex_branch;
  logic              id_ex_branch_bne;
  logic [DATA_W-1:0] id_ex_reg_read_data1;
  logic [DATA_W-1:0] id_ex_reg_read_data2;
  logic [4:0]        id_ex_rs;
  logic [4:0]        id_ex_rt;
  logic [4:0]        id_ex_rd;
  logic [DATA_W-1:0] id_ex_sign_extended;
  logic [DATA_W-1:0] ex_mem_alu_result;
  logic [DATA_W-1:0] wb_write_data;
  logic [4:0]        ex_mem_rd;
  logic [4:0]        mem_wb_rd;
  logic              ex_mem_reg_write_in;
  logic              mem_wb_reg_write;

  logic [DATA_W-1:0] ex_mem_alu_result_out;
  logic [DATA_W-1:0] ex_mem_reg_read_data2;
  logic [4:0]        ex_mem_rd_out;
  logic              ex_mem_mem_read;
  logic              ex_mem_mem_write;
  logic              ex_mem_mem_to_reg;
  logic              ex_mem_reg_write;
  logic              ex_mem_branch;
  logic              ex_mem_branch_bne;
  logic [4:0]        id_ex_rt_out;
  logic              id_ex_mem_read_out;
  logic              ex_stall;
  logic              md_busy;

  modport master (
    output pridictor_wrong, id_ex_alu_op, id_ex_reg_dst, id_ex_alu_src,
           id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_reg_write,
           id_ex_branch, id_ex_branch_bne, id_ex_reg_read_data1, id_ex_reg_read_data2,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_sign_extended,
           ex_mem_alu_result, wb_write_data, ex_mem_rd, mem_wb_rd,
           ex_mem_reg_write_in, mem_wb_reg_write,
    input  ex_mem_alu_result_out, ex_mem_reg_read_data2, ex_mem_rd_out,
           ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg, ex_mem_reg_write,
           ex_mem_branch, ex_mem_branch_bne, id_ex_rt_out, id_ex_mem_read_out,
           ex_stall, md_busy
  );

  modport slave (
    input  pridictor_wrong, id_ex_alu_op, id_ex_reg_dst, id_ex_alu_src,
           id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_reg_write,
           id_ex_branch, id_ex_branch_bne, id_ex_reg_read_data1, id_ex_reg_read_data2,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_sign_extended,
           ex_mem_alu_result, wb_write_data, ex_mem_rd, mem_wb_rd,
           ex_mem_reg_write_in, mem_wb_reg_write,
    output ex_mem_alu_result_out, ex_mem_reg_read_data2, ex_mem_rd_out,
           ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg, ex_mem_reg_write,
           ex_mem_branch, ex_mem_branch_bne, id_ex_rt_out, id_ex_mem_read_out,
           ex_stall, md_busy
  );
endinterface

// File: rtl/ex_stage_muldiv.sv
// EX stage: operand forwarding, single-cycle ALU, EX/MEM register, and an iterative
// multiply/divide unit with HI/LO that stalls only instructions that depend on it.
module ex_stage_muldiv #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input logic              clk,
  input logic              rst_n,
  ex_stage_muldiv_if.slave bus
);
  localparam int unsigned P_W = 2 * DATA_W;

  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

  md_state_e         state_q, state_d;
  logic              accept, finish;

  logic [1:0]        fwd_sel_a, fwd_sel_b;
  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res;
  logic [5:0]        funct;
  logic [SHAMT_W-1:0] shamt;
  logic              is_r, is_md, is_mf, flush, bubble;
  logic [4:0]        dest;

  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] md_a_q;
  logic [P_W-1:0]    md_p_q;
  logic              md_div_q, md_neg_lo_q, md_neg_hi_q, md_dz_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic [DATA_W:0]   mul_sum, div_rem_sh, div_diff;
  logic              div_ge;
  logic [P_W-1:0]    mul_next, div_next, step_p, prod_fix;
  logic [DATA_W-1:0] quo, rem, quo_fix, rem_fix;

  logic              op_signed, a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;

  assign flush = bus.pridictor_wrong;
  assign funct = bus.id_ex_sign_extended[5:0];
  assign shamt = bus.id_ex_sign_extended[6 +: SHAMT_W];
  assign is_r  = (bus.id_ex_alu_op == 4'b0010);
  assign is_md = is_r && (funct[5:2] == 4'b0110);
  assign is_mf = is_r && (funct == 6'b010000 || funct == 6'b010010);
  assign dest  = bus.id_ex_reg_dst ? bus.id_ex_rd : bus.id_ex_rt;

  // EX/MEM has priority over MEM/WB; register 0 is never forwarded
  always_comb begin
    fwd_sel_a = 2'b00;
    fwd_sel_b = 2'b00;
    if (bus.ex_mem_reg_write_in && bus.ex_mem_rd != 5'd0 && bus.ex_mem_rd == bus.id_ex_rs)
      fwd_sel_a = 2'b10;
    else if (bus.mem_wb_reg_write && bus.mem_wb_rd != 5'd0 && bus.mem_wb_rd == bus.id_ex_rs)
      fwd_sel_a = 2'b01;
    if (bus.ex_mem_reg_write_in && bus.ex_mem_rd != 5'd0 && bus.ex_mem_rd == bus.id_ex_rt)
      fwd_sel_b = 2'b10;
    else if (bus.mem_wb_reg_write && bus.mem_wb_rd != 5'd0 && bus.mem_wb_rd == bus.id_ex_rt)
      fwd_sel_b = 2'b01;
  end

  always_comb begin
    case (fwd_sel_a)
      2'b10:   fwd_a = bus.ex_mem_alu_result;
      2'b01:   fwd_a = bus.wb_write_data;
      default: fwd_a = bus.id_ex_reg_read_data1;
    endcase
    case (fwd_sel_b)
      2'b10:   fwd_b = bus.ex_mem_alu_result;
      2'b01:   fwd_b = bus.wb_write_data;
      default: fwd_b = bus.id_ex_reg_read_data2;
    endcase
  end

  assign alu_b = bus.id_ex_alu_src ? bus.id_ex_sign_extended : fwd_b;

  always_comb begin
    alu_res = '0;
    if (is_r) begin
      case (funct)
        6'b100000, 6'b100001: alu_res = fwd_a + alu_b;
        6'b100010, 6'b100011: alu_res = fwd_a - alu_b;
        6'b100100:            alu_res = fwd_a & alu_b;
        6'b100101:            alu_res = fwd_a | alu_b;
        6'b100110:            alu_res = fwd_a ^ alu_b;
        6'b100111:            alu_res = ~(fwd_a | alu_b);
        6'b101010:            alu_res = DATA_W'($signed(fwd_a) < $signed(alu_b));
        6'b101011:            alu_res = DATA_W'(fwd_a < alu_b);
        6'b000000:            alu_res = fwd_b << shamt;
        6'b000010:            alu_res = fwd_b >> shamt;
        6'b000011:            alu_res = DATA_W'($signed(fwd_b) >>> shamt);
        6'b010000:            alu_res = hi_q;
        6'b010010:            alu_res = lo_q;
        default:              alu_res = '0;
      endcase
    end else begin
      case (bus.id_ex_alu_op)
        4'b0000, 4'b0100: alu_res = fwd_a + alu_b;
        4'b0001:          alu_res = fwd_a - alu_b;
        4'b0101:          alu_res = fwd_a & alu_b;
        4'b0110:          alu_res = fwd_a | alu_b;
        4'b0111:          alu_res = DATA_W'($signed(fwd_a) < $signed(alu_b));
        4'b1000:          alu_res = fwd_a ^ alu_b;
        default:          alu_res = '0;
      endcase
    end
  end

  // Only instructions touching HI/LO or the unit wait; everything else overlaps
  assign bus.ex_stall           = !flush && bus.md_busy && (is_md || is_mf);
  assign bus.id_ex_rt_out       = flush ? 5'd0 : bus.id_ex_rt;
  assign bus.id_ex_mem_read_out = flush ? 1'b0 : bus.id_ex_mem_read;

  // Mul/div never writes EX/MEM itself; its result reaches the pipe through MFHI/MFLO
  assign bubble = flush || bus.ex_stall || is_md;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_mem_alu_result_out <= '0;
      bus.ex_mem_reg_read_data2 <= '0;
      bus.ex_mem_rd_out         <= '0;
      bus.ex_mem_mem_read       <= 1'b0;
      bus.ex_mem_mem_write      <= 1'b0;
      bus.ex_mem_mem_to_reg     <= 1'b0;
      bus.ex_mem_reg_write      <= 1'b0;
      bus.ex_mem_branch         <= 1'b0;
      bus.ex_mem_branch_bne     <= 1'b0;
    end else if (bubble) begin
      bus.ex_mem_alu_result_out <= '0;
      bus.ex_mem_reg_read_data2 <= '0;
      bus.ex_mem_rd_out         <= '0;
      bus.ex_mem_mem_read       <= 1'b0;
      bus.ex_mem_mem_write      <= 1'b0;
      bus.ex_mem_mem_to_reg     <= 1'b0;
      bus.ex_mem_reg_write      <= 1'b0;
      bus.ex_mem_branch         <= 1'b0;
      bus.ex_mem_branch_bne     <= 1'b0;
    end else begin
      bus.ex_mem_alu_result_out <= alu_res;
      bus.ex_mem_reg_read_data2 <= fwd_b;
      bus.ex_mem_rd_out         <= dest;
      bus.ex_mem_mem_read       <= bus.id_ex_mem_read;
      bus.ex_mem_mem_write      <= bus.id_ex_mem_write;
      bus.ex_mem_mem_to_reg     <= bus.id_ex_mem_to_reg;
      bus.ex_mem_reg_write      <= bus.id_ex_reg_write;
      bus.ex_mem_branch         <= bus.id_ex_branch;
      bus.ex_mem_branch_bne     <= bus.id_ex_branch_bne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      MD_IDLE: if (is_md && !flush) begin
        accept  = 1'b1;
        state_d = MD_BUSY;
      end
      MD_BUSY: if (cnt_q == SHAMT_W'(DATA_W - 1)) begin
        finish  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign bus.md_busy = (state_q == MD_BUSY);

  // Operand magnitudes: MULT/DIV are signed (funct[0]=0), the U variants unsigned
  assign op_signed = !funct[0];
  assign a_neg     = op_signed && fwd_a[DATA_W-1];
  assign b_neg     = op_signed && fwd_b[DATA_W-1];
  assign a_mag     = a_neg ? -fwd_a : fwd_a;
  assign b_mag     = b_neg ? -fwd_b : fwd_b;

  // One shift-add or restoring-subtract step; md_p_q = {upper/remainder, multiplier/quotient}
  assign mul_sum    = {1'b0, md_p_q[P_W-1:DATA_W]} + (md_p_q[0] ? {1'b0, md_a_q} : '0);
  assign mul_next   = {mul_sum, md_p_q[DATA_W-1:1]};
  assign div_rem_sh = {md_p_q[P_W-1:DATA_W], md_p_q[DATA_W-1]};
  assign div_diff   = div_rem_sh - {1'b0, md_a_q};
  assign div_ge     = !div_diff[DATA_W];
  assign div_next   = {(div_ge ? div_diff[DATA_W-1:0] : div_rem_sh[DATA_W-1:0]),
                       md_p_q[DATA_W-2:0], div_ge};
  assign step_p     = md_div_q ? div_next : mul_next;

  // Divide by zero leaves remainder = |dividend| so the sign fix restores the dividend
  assign prod_fix = md_neg_lo_q ? -step_p : step_p;
  assign quo      = step_p[DATA_W-1:0];
  assign rem      = step_p[P_W-1:DATA_W];
  assign quo_fix  = md_dz_q ? '1 : (md_neg_lo_q ? -quo : quo);
  assign rem_fix  = md_neg_hi_q ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q        <= '0;
      lo_q        <= '0;
      md_a_q      <= '0;
      md_p_q      <= '0;
      md_div_q    <= 1'b0;
      md_neg_lo_q <= 1'b0;
      md_neg_hi_q <= 1'b0;
      md_dz_q     <= 1'b0;
      cnt_q       <= '0;
    end else if (accept) begin
      md_div_q    <= funct[1];
      md_neg_lo_q <= a_neg ^ b_neg;
      md_neg_hi_q <= funct[1] && a_neg;
      md_dz_q     <= funct[1] && (fwd_b == '0);
      md_a_q      <= funct[1] ? b_mag : a_mag;
      md_p_q      <= {{DATA_W{1'b0}}, (funct[1] ? a_mag : b_mag)};
      cnt_q       <= '0;
    end else if (state_q == MD_BUSY) begin
      md_p_q <= step_p;
      cnt_q  <= cnt_q + 1'b1;
      if (finish) begin
        if (md_div_q) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          hi_q <= prod_fix[P_W-1:DATA_W];
          lo_q <= prod_fix[DATA_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Self-checking bench for ex_stage_muldiv: ALU vector table, forwarding,
// mul/div sequences with stall, overlap, flush and reset corner cases.
module tb_ex_stage_muldiv;
  localparam int unsigned W = 32;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_stage_muldiv_if #(.DATA_W(W)) bus();
  ex_stage_muldiv #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [95:0]  name;
    logic [W-1:0] res;
    logic [W-1:0] d2;
    logic [4:0]   rd;
    logic         rw;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [5:0]   funct;
    logic [4:0]   shamt;
    logic         src;
    logic [W-1:0] a, b, imm, exp;
  } vec_t;

  exp_t sb[$];
  vec_t vt[18];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input logic [95:0] name, input logic [W-1:0] res, input logic [W-1:0] d2,
                      input logic [4:0] rd, input logic rw);
    exp_t e;
    e.name = name; e.res = res; e.d2 = d2; e.rd = rd; e.rw = rw;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [95:0] name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %0s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance one edge and compare the EX/MEM register against the oldest expectation
  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.ex_mem_alu_result_out !== e.res || bus.ex_mem_reg_read_data2 !== e.d2 ||
          bus.ex_mem_rd_out !== e.rd || bus.ex_mem_reg_write !== e.rw) begin
        errors++;
        $display("FAIL %0s: got res=%h d2=%h rd=%0d rw=%b expected res=%h d2=%h rd=%0d rw=%b",
                 e.name, bus.ex_mem_alu_result_out, bus.ex_mem_reg_read_data2,
                 bus.ex_mem_rd_out, bus.ex_mem_reg_write, e.res, e.d2, e.rd, e.rw);
      end
    end
  endtask

  task automatic nop_in();
    bus.pridictor_wrong = 0; bus.id_ex_alu_op = 4'b0000; bus.id_ex_reg_dst = 0;
    bus.id_ex_alu_src = 0; bus.id_ex_mem_read = 0; bus.id_ex_mem_write = 0;
    bus.id_ex_mem_to_reg = 0; bus.id_ex_reg_write = 0; bus.id_ex_branch = 0;
    bus.id_ex_branch_bne = 0; bus.id_ex_reg_read_data1 = '0; bus.id_ex_reg_read_data2 = '0;
    bus.id_ex_rs = 0; bus.id_ex_rt = 0; bus.id_ex_rd = 0; bus.id_ex_sign_extended = '0;
    bus.ex_mem_alu_result = '0; bus.wb_write_data = '0; bus.ex_mem_rd = 0; bus.mem_wb_rd = 0;
    bus.ex_mem_reg_write_in = 0; bus.mem_wb_reg_write = 0;
  endtask

  task automatic rtype(input logic [5:0] funct, input logic [4:0] shamt, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] rd, input logic rw);
    nop_in();
    bus.id_ex_alu_op = 4'b0010; bus.id_ex_reg_dst = 1; bus.id_ex_reg_write = rw;
    bus.id_ex_rs = 5'd1; bus.id_ex_rt = 5'd2; bus.id_ex_rd = rd;
    bus.id_ex_reg_read_data1 = a; bus.id_ex_reg_read_data2 = b;
    bus.id_ex_sign_extended = (W'(shamt) << 6) | W'(funct);
  endtask

  task automatic md_issue(input logic [5:0] funct, input logic [W-1:0] a, input logic [W-1:0] b);
    rtype(funct, 5'd0, a, b, 5'd0, 1'b0);
    push("md_issue", '0, '0, 5'd0, 1'b0);
    tick();
  endtask

  // Issue MFHI/MFLO to rd 9 and hold it until the stage stops stalling
  task automatic mf_read(input logic [5:0] funct, input logic [W-1:0] exp,
                         input logic [95:0] name, output int stalls);
    bit done;
    rtype(funct, 5'd0, '0, '0, 5'd9, 1'b1);
    bus.id_ex_rt = 5'd0;
    stalls = 0;
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      #1;
      if (bus.ex_stall) begin
        stalls++;
        push(name, '0, '0, 5'd0, 1'b0);
      end else begin
        push(name, exp, '0, 5'd9, 1'b1);
        done = 1;
      end
      tick();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %0s: still stalled after 80 cycles", name);
    end
    nop_in();
  endtask

  task automatic wait_idle();
    bit done;
    nop_in();
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (!bus.md_busy) done = 1;
      else begin
        push("idle_wait", '0, '0, 5'd0, 1'b0);
        tick();
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_idle: md_busy never dropped");
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, busy;
    bit busy_done;

    //            op       funct      sh  src a             b             imm           exp
    vt[0]  = '{4'b0010, 6'b100000, 0, 0, 32'd5,        32'd7,        '0,           32'd12};
    vt[1]  = '{4'b0010, 6'b100011, 0, 0, 32'd5,        32'd7,        '0,           32'hFFFFFFFE};
    vt[2]  = '{4'b0010, 6'b100100, 0, 0, 32'h0000F0F0, 32'h0000FF00, '0,           32'h0000F000};
    vt[3]  = '{4'b0010, 6'b100101, 0, 0, 32'h0000F0F0, 32'h0000FF00, '0,           32'h0000FFF0};
    vt[4]  = '{4'b0010, 6'b100110, 0, 0, 32'h0000F0F0, 32'h0000FF00, '0,           32'h00000FF0};
    vt[5]  = '{4'b0010, 6'b100111, 0, 0, 32'd0,        32'd0,        '0,           32'hFFFFFFFF};
    vt[6]  = '{4'b0010, 6'b101010, 0, 0, 32'hFFFFFFFF, 32'd1,        '0,           32'd1};
    vt[7]  = '{4'b0010, 6'b101011, 0, 0, 32'hFFFFFFFF, 32'd1,        '0,           32'd0};
    vt[8]  = '{4'b0010, 6'b000000, 31, 0, 32'd0,       32'd1,        '0,           32'h80000000};
    vt[9]  = '{4'b0010, 6'b000010, 4, 0, 32'd0,        32'h80000000, '0,           32'h08000000};
    vt[10] = '{4'b0010, 6'b000011, 4, 0, 32'd0,        32'h80000000, '0,           32'hF8000000};
    vt[11] = '{4'b0010, 6'b111111, 0, 0, 32'd5,        32'd7,        '0,           32'd0};
    vt[12] = '{4'b0000, 6'b000000, 0, 1, 32'd10,       32'd99,       32'hFFFFFFFF, 32'd9};
    vt[13] = '{4'b0001, 6'b000000, 0, 0, 32'd10,       32'd3,        '0,           32'd7};
    vt[14] = '{4'b0101, 6'b000000, 0, 0, 32'h0F0F0F0F, 32'h00FF00FF, '0,           32'h000F000F};
    vt[15] = '{4'b0111, 6'b000000, 0, 0, 32'd3,        32'd5,        '0,           32'd1};
    vt[16] = '{4'b1000, 6'b000000, 0, 0, 32'hAAAA0000, 32'hFFFF0000, '0,           32'h55550000};
    vt[17] = '{4'b1111, 6'b000000, 0, 0, 32'd3,        32'd5,        '0,           32'd0};

    nop_in();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", bus.ex_mem_alu_result_out, '0);
    chk("rst_rd", W'(bus.ex_mem_rd_out), '0);
    chk("rst_rw", W'(bus.ex_mem_reg_write), '0);
    chk("rst_busy", W'(bus.md_busy), '0);
    rst_n = 1;

    foreach (vt[i]) begin
      nop_in();
      bus.id_ex_alu_op = vt[i].op; bus.id_ex_reg_dst = (vt[i].op == 4'b0010);
      bus.id_ex_alu_src = vt[i].src; bus.id_ex_reg_write = 1;
      bus.id_ex_rs = 5'd1; bus.id_ex_rt = 5'd2; bus.id_ex_rd = 5'd3;
      bus.id_ex_reg_read_data1 = vt[i].a; bus.id_ex_reg_read_data2 = vt[i].b;
      bus.id_ex_sign_extended = (vt[i].op == 4'b0010) ?
          ((W'(vt[i].shamt) << 6) | W'(vt[i].funct)) : vt[i].imm;
      push("alu_vec", vt[i].exp, vt[i].b, (vt[i].op == 4'b0010) ? 5'd3 : 5'd2, 1'b1);
      tick();
    end

    // r1 from EX/MEM, r2 from MEM/WB
    nop_in();
    bus.id_ex_alu_op = 4'b0010; bus.id_ex_reg_dst = 1; bus.id_ex_reg_write = 1;
    bus.id_ex_rs = 1; bus.id_ex_rt = 2; bus.id_ex_rd = 3;
    bus.id_ex_reg_read_data1 = 32'hDEAD; bus.id_ex_reg_read_data2 = 32'hBEEF;
    bus.id_ex_sign_extended = 32'h20;
    bus.ex_mem_reg_write_in = 1; bus.ex_mem_rd = 1; bus.ex_mem_alu_result = 32'd5;
    bus.mem_wb_reg_write = 1; bus.mem_wb_rd = 2; bus.wb_write_data = 32'd7;
    #1 chk("rt_out", W'(bus.id_ex_rt_out), W'(5'd2));
    push("fwd_both", 32'd12, 32'd7, 5'd3, 1'b1);
    tick();

    // Both sources match rs: EX/MEM wins; rt = r0 never forwarded
    bus.id_ex_rs = 4; bus.id_ex_rt = 0; bus.id_ex_reg_read_data2 = '0;
    bus.ex_mem_rd = 4; bus.ex_mem_alu_result = 32'h11;
    bus.mem_wb_rd = 4; bus.wb_write_data = 32'h22;
    push("fwd_prio", 32'h11, '0, 5'd3, 1'b1);
    tick();

    bus.id_ex_rs = 0; bus.id_ex_rt = 2; bus.id_ex_reg_read_data1 = '0;
    bus.id_ex_reg_read_data2 = 32'd4; bus.ex_mem_rd = 0; bus.ex_mem_alu_result = 32'h99;
    bus.mem_wb_rd = 0;
    push("fwd_r0", 32'd4, 32'd4, 5'd3, 1'b1);
    tick();

    md_issue(F_MULT, 32'hFFFFFFFE, 32'd3);
    mf_read(F_MFLO, 32'hFFFFFFFA, "mult_lo", stalls);
    chk("mult_stalls", W'(stalls), W'(W));
    mf_read(F_MFHI, 32'hFFFFFFFF, "mult_hi", stalls);
    chk("mfhi_nostall", W'(stalls), '0);

    md_issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    mf_read(F_MFLO, 32'hFFFFFFFD, "div_lo", stalls);
    mf_read(F_MFHI, 32'hFFFFFFFF, "div_hi", stalls);

    md_issue(F_DIVU, 32'd7, 32'd0);
    mf_read(F_MFLO, 32'hFFFFFFFF, "divz_lo", stalls);
    mf_read(F_MFHI, 32'd7, "divz_hi", stalls);

    md_issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    mf_read(F_MFLO, 32'h80000000, "dmin_lo", stalls);
    mf_read(F_MFHI, 32'd0, "dmin_hi", stalls);

    // Independent ADDs overlap the multiply without stalling
    md_issue(F_MULTU, 32'hFFFFFFFF, 32'd2);
    busy = 0;
    busy_done = 0;
    for (int i = 0; i < 70 && !busy_done; i++) begin
      if (!bus.md_busy) busy_done = 1;
      else begin
        busy++;
        if (i < 5) begin
          rtype(6'b100000, 5'd0, W'(i * 100), W'(i + 1), 5'(10 + i), 1'b1);
          #1 chk("ovl_stall", W'(bus.ex_stall), '0);
          push("ovl_add", W'(i * 100 + i + 1), W'(i + 1), 5'(10 + i), 1'b1);
        end else begin
          nop_in();
          push("ovl_nop", '0, '0, 5'd0, 1'b0);
        end
        tick();
      end
    end
    chk("multu_busy", W'(busy), W'(W));
    mf_read(F_MFLO, 32'hFFFFFFFE, "multu_lo", stalls);
    mf_read(F_MFHI, 32'd1, "multu_hi", stalls);

    // Stalled MFHI squashed by a mispredict; the multiply still finishes
    md_issue(F_MULT, 32'd3, 32'd4);
    rtype(F_MFHI, 5'd0, '0, '0, 5'd9, 1'b1);
    bus.id_ex_mem_read = 1;
    #1 chk("mf_stall", W'(bus.ex_stall), W'(1));
    push("mf_stalled", '0, '0, 5'd0, 1'b0);
    tick();
    bus.pridictor_wrong = 1;
    #1 chk("flush_stall", W'(bus.ex_stall), '0);
    chk("flush_rt", W'(bus.id_ex_rt_out), '0);
    chk("flush_mrd", W'(bus.id_ex_mem_read_out), '0);
    push("flush_bub", '0, '0, 5'd0, 1'b0);
    tick();
    chk("flush_busy", W'(bus.md_busy), W'(1));
    wait_idle();
    mf_read(F_MFLO, 32'd12, "flush_lo", stalls);
    mf_read(F_MFHI, 32'd0, "flush_hi", stalls);

    // A mul/div under flush is not accepted
    rtype(F_MULT, 5'd0, 32'd9, 32'd9, 5'd0, 1'b0);
    bus.pridictor_wrong = 1;
    push("flush_md", '0, '0, 5'd0, 1'b0);
    tick();
    chk("flush_noacc", W'(bus.md_busy), '0);
    nop_in();

    // Reset in the middle of an operation clears HI/LO and aborts
    md_issue(F_MULT, 32'd5, 32'd6);
    repeat (3) begin
      push("pre_rst", '0, '0, 5'd0, 1'b0);
      tick();
    end
    rst_n = 0;
    #1 chk("rst_mid_busy", W'(bus.md_busy), '0);
    @(posedge clk); #1;
    rst_n = 1;
    mf_read(F_MFLO, 32'd0, "rst_lo", stalls);
    chk("rst_lo_nostall", W'(stalls), '0);
    mf_read(F_MFHI, 32'd0, "rst_hi", stalls);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
